approx_mult_sweep_ctrl: RTL and testbench
=========================================

# approx_mult_sweep_ctrl

Hardware error-characterization sequencer for a 4x4 approximate multiplier. On a start pulse it sweeps every operand pair (a outer, b inner, 0..2^W-1 each) through an external combinational multiplier under test. For each pair it waits a programmable settle time, samples the product and compares it against an internal exact product. It accumulates the match count, total error distance and maximum error distance. It sits beside a multiplier instance on the characterization path and replaces exhaustive simulation loops for on-board or emulation accuracy measurement.

## Interface
Parameters:
- W, 4, operand width of multiplier under test
- SETTLE, 1, cycles operands are held before the product is sampled (legal range 1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; accepted only in IDLE, ignored otherwise
- mul_a  out  W  operand a to multiplier under test
- mul_b  out  W  operand b to multiplier under test
- mul_y  in  2W  product from multiplier under test (combinational from mul_a/mul_b)
- busy  out  1  high in DRIVE and SAMPLE
- done  out  1  one-cycle pulse when sweep completes
- correct_cnt  out  2W+1  pairs with mul_y == a*b (max 256 at W=4)
- total_err  out  4W  sum over pairs of |mul_y − a*b|
- max_err  out  2W  maximum |mul_y − a*b| seen

## Operation
- Internal index idx (2W bits): mul_a = idx[2W-1:W], mul_b = idx[W-1:0]. mul_a and mul_b are registered outputs.
- States:
  - IDLE: start=1 → clear correct_cnt, total_err, max_err, idx, settle counter; go to DRIVE.
  - DRIVE: hold operands; count SETTLE cycles, then go to SAMPLE.
  - SAMPLE: sample mul_y; compute exact = mul_a*mul_b (2W bits, unsigned) and err = |mul_y − exact| (2W bits, unsigned magnitude).
    - If err==0, correct_cnt += 1.
    - total_err += err, zero-extended.
    - If err > max_err, max_err = err.
    - If idx == 2^(2W)−1 → DONE; else idx += 1 → DRIVE.
  - DONE: done=1 for this cycle only; idx cleared to 0; go to IDLE.
- Result outputs hold their final values from DONE until the next accepted start.
- Accumulator widths are sized so no overflow is possible; no saturation logic.
- start during DRIVE, SAMPLE or DONE is ignored. It is not queued.

## Timing
- Reset values: state IDLE, mul_a=0, mul_b=0, busy=0, done=0, correct_cnt=0, total_err=0, max_err=0.
- Reset mid-sweep: next cycle is IDLE with all outputs at reset values. No done pulse is issued. Partial results are discarded.
- Start accepted at edge k: the DRIVE state for idx=0 begins at edge k+1.
- Per pair: SETTLE cycles in DRIVE plus 1 cycle in SAMPLE. Operands are constant across all of them.
- Sweep length: 2^(2W)·(SETTLE+1) cycles, then 1 cycle in DONE.
  - W=4, SETTLE=1: done is high in cycle k+513.
  - W=4, SETTLE=3: done is high in cycle k+1025.
- Results are updated at the SAMPLE edge. Final values are valid in the same cycle done is high.
- busy falls in the DONE cycle. A new start is accepted from the first IDLE cycle after DONE.

## Test plan
- Exact multiplier model (mul_y = a*b), W=4, SETTLE=1, start pulse → correct_cnt=256, total_err=0, max_err=0, done high exactly 513 cycles after start acceptance, busy high for 512 cycles.
- Stub mul_y=0 → correct_cnt=31, total_err=14400, max_err=225.
- Stub mul_y = (a*b)|1 → correct_cnt=64, total_err=192, max_err=1. Also check mul_a/mul_b step through 0x00..0xFF in a-outer order, each held for 2 cycles.
- Reset asserted at cycle 200 of a sweep → next cycle all outputs zero, no done pulse. A fresh start then yields full correct results.
- start held high or re-pulsed while busy → single sweep, results identical to the single-pulse case. Re-start after done → results cleared, then reproduced.
- SETTLE=3 with a model whose mul_y lags operands by 2 cycles → correct_cnt=256 and done at cycle k+1025. The same model with SETTLE=1 gives correct_cnt<256.

Source files
------------

// File: rtl/approx_mult_sweep_ctrl.sv
// approx_mult_sweep_ctrl
// Error-characterization sequencer for an external W x W approximate multiplier.
// Sweeps every operand pair (a outer, b inner), lets the product settle for
// SETTLE cycles, then compares it with the exact product. It accumulates the
// number of exact matches, the summed error distance and the largest error distance.
module approx_mult_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_y,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     correct_cnt,
  output logic [4*W-1:0]   total_err,
  output logic [2*W-1:0]   max_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2*W-1:0] IDX_LAST    = '1;

  state_t           state_q, state_d;
  logic [2*W-1:0]   idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [2*W:0]     correct_cnt_q, correct_cnt_d;
  logic [4*W-1:0]   total_err_q, total_err_d;
  logic [2*W-1:0]   max_err_q, max_err_d;
  logic [2*W-1:0]   exact;
  logic [2*W-1:0]   err;

  // State and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      correct_cnt_q <= '0;
      total_err_q   <= '0;
      max_err_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      settle_q      <= settle_d;
      correct_cnt_q <= correct_cnt_d;
      total_err_q   <= total_err_d;
      max_err_q     <= max_err_d;
    end
  end

  // Next-state logic: start only matters in IDLE, so repeated pulses are harmless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == IDX_LAST) ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Exact reference product of the operands currently driven, and the error distance.
  always_comb begin
    exact = (2*W)'(idx_q[2*W-1:W]) * (2*W)'(idx_q[W-1:0]);
    err   = (mul_y >= exact) ? (mul_y - exact) : (exact - mul_y);
  end

  // Datapath updates: clear on accepted start, settle count in DRIVE, accumulate in SAMPLE.
  always_comb begin
    idx_d         = idx_q;
    settle_d      = settle_q;
    correct_cnt_d = correct_cnt_q;
    total_err_d   = total_err_q;
    max_err_d     = max_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d         = '0;
          settle_d      = '0;
          correct_cnt_d = '0;
          total_err_d   = '0;
          max_err_d     = '0;
        end
      end
      DRIVE: begin
        settle_d = (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
      end
      SAMPLE: begin
        if (err == '0) correct_cnt_d = correct_cnt_q + (2*W+1)'(1);
        total_err_d = total_err_q + {{(2*W){1'b0}}, err};
        if (err > max_err_q) max_err_d = err;
        if (idx_q != IDX_LAST) idx_d = idx_q + (2*W)'(1);
      end
      DONE: begin
        idx_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state and index.
  always_comb begin
    busy        = (state_q == DRIVE) || (state_q == SAMPLE);
    done        = (state_q == DONE);
    mul_a       = idx_q[2*W-1:W];
    mul_b       = idx_q[W-1:0];
    correct_cnt = correct_cnt_q;
    total_err   = total_err_q;
    max_err     = max_err_q;
  end

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// Testbench for approx_mult_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// driven by selectable multiplier models, with results predicted by direct
// enumeration of all operand pairs.
module tb_approx_mult_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         mode;
  int         which;
  int         tests = 0;
  int         fails = 0;

  logic [7:0] rnd_tab [256];

  logic [3:0] a1, b1, a3, b3;
  logic [7:0] y1, y3;
  logic       busy1, busy3, done1, done3;
  logic [8:0] cnt1, cnt3;
  logic [15:0] tot1, tot3;
  logic [7:0] max1, max3;
  logic [7:0] lag1_q1, lag1_q2, lag3_q1, lag3_q2;

  logic [3:0] o_a, o_b;
  logic       o_busy, o_done;
  logic [8:0] o_cnt;
  logic [15:0] o_tot;
  logic [7:0] o_max;

  int exp_cnt, exp_sum, exp_max;

  approx_mult_sweep_ctrl #(.W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start && which == 0),
    .mul_a(a1), .mul_b(b1), .mul_y(y1),
    .busy(busy1), .done(done1),
    .correct_cnt(cnt1), .total_err(tot1), .max_err(max1)
  );

  approx_mult_sweep_ctrl #(.W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start && which == 1),
    .mul_a(a3), .mul_b(b3), .mul_y(y3),
    .busy(busy3), .done(done3),
    .correct_cnt(cnt3), .total_err(tot3), .max_err(max3)
  );

  always #5 clk = ~clk;

  // Multiplier models: 0 exact, 1 stuck at zero, 2 exact with LSB forced, 4 random table.
  function automatic logic [7:0] model_y(input int m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    case (m)
      0:       return p;
      1:       return 8'd0;
      2:       return p | 8'd1;
      4:       return rnd_tab[{a, b}];
      default: return p;
    endcase
  endfunction

  // Mode 3: exact product delayed by two clock cycles after the operands change.
  always @(posedge clk) begin
    lag1_q1 <= 8'(a1) * 8'(b1);
    lag1_q2 <= lag1_q1;
    lag3_q1 <= 8'(a3) * 8'(b3);
    lag3_q2 <= lag3_q1;
  end

  always_comb begin
    y1 = (mode == 3) ? lag1_q2 : model_y(mode, a1, b1);
    y3 = (mode == 3) ? lag3_q2 : model_y(mode, a3, b3);
  end

  always_comb begin
    o_a    = (which == 1) ? a3    : a1;
    o_b    = (which == 1) ? b3    : b1;
    o_busy = (which == 1) ? busy3 : busy1;
    o_done = (which == 1) ? done3 : done1;
    o_cnt  = (which == 1) ? cnt3  : cnt1;
    o_tot  = (which == 1) ? tot3  : tot1;
    o_max  = (which == 1) ? max3  : max1;
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Reference: enumerate every pair and accumulate match count, error sum and max.
  task automatic computeExpected(input int m);
    int y, ex, e;
    exp_cnt = 0;
    exp_sum = 0;
    exp_max = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        y  = int'(model_y(m, 4'(a), 4'(b)));
        ex = a * b;
        e  = (y > ex) ? y - ex : ex - y;
        if (e == 0) exp_cnt++;
        exp_sum += e;
        if (e > exp_max) exp_max = e;
      end
    end
  endtask

  // One full sweep: hold_mode 0 single pulse, 1 start held high, 2 extra pulses while busy.
  task automatic applyStimulus(input int w, input int m, input int hold_mode);
    int settle, per_pair, done_at, busy_cnt, step_err;
    int cnt_at, tot_at, max_at;
    settle   = (w == 1) ? 3 : 1;
    per_pair = settle + 1;
    which    = w;
    mode     = m;
    computeExpected(m);
    done_at  = 0;
    busy_cnt = 0;
    step_err = 0;
    cnt_at   = 0;
    tot_at   = 0;
    max_at   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 3000 && done_at == 0; n++) begin
      @(negedge clk);
      if (hold_mode == 0) start = 1'b0;
      else if (hold_mode == 2) start = (n == 50 || n == 300);
      if (n == 1) begin
        checkOutput("cleared_cnt", o_cnt, 0);
        checkOutput("cleared_tot", o_tot, 0);
      end
      if (o_busy) begin
        busy_cnt++;
        if (int'({o_a, o_b}) != (n - 1) / per_pair) step_err++;
      end
      if (o_done) begin
        done_at = n;
        cnt_at  = int'(o_cnt);
        tot_at  = int'(o_tot);
        max_at  = int'(o_max);
        start   = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("done_latency", done_at, 256 * per_pair + 1);
    checkOutput("busy_cycles", busy_cnt, 256 * per_pair);
    checkOutput("operand_steps", step_err, 0);
    if (m == 3 && w == 0) begin
      checkOutput("lag_settle1_some_wrong", (cnt_at < 256), 1);
    end else begin
      checkOutput("correct_cnt", cnt_at, exp_cnt);
      checkOutput("total_err", tot_at, exp_sum);
      checkOutput("max_err", max_at, exp_max);
    end
    @(negedge clk);
    checkOutput("done_one_cycle", o_done, 0);
    checkOutput("busy_idle", o_busy, 0);
    checkOutput("result_hold", o_cnt, cnt_at);
  endtask

  // Checks every output of the selected instance against its reset value.
  task automatic checkZero(input string tag);
    checkOutput({tag, "_a"}, o_a, 0);
    checkOutput({tag, "_b"}, o_b, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_cnt"}, o_cnt, 0);
    checkOutput({tag, "_tot"}, o_tot, 0);
    checkOutput({tag, "_max"}, o_max, 0);
  endtask

  // Directed sequence of sweeps covering each model and control corner.
  initial begin
    int saw_done;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    which = 0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_tab[i] = 8'(i[7:4]) * 8'(i[3:0]);
      else rnd_tab[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    which = 0;
    checkZero("reset1");
    which = 1;
    checkZero("reset3");

    applyStimulus(0, 0, 0);
    checkOutput("exact_cnt_256", o_cnt, 256);
    applyStimulus(0, 1, 0);
    checkOutput("zero_cnt_31", o_cnt, 31);
    applyStimulus(0, 2, 0);
    checkOutput("or1_max_1", o_max, 1);

    which = 0;
    mode  = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkZero("midreset");
    saw_done = 0;
    repeat (600) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done++;
    end
    checkOutput("no_done_after_reset", saw_done, 0);
    applyStimulus(0, 0, 0);

    applyStimulus(0, 2, 1);
    applyStimulus(0, 2, 2);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    applyStimulus(0, 4, 0);
    applyStimulus(1, 4, 0);

    applyStimulus(1, 3, 0);
    checkOutput("lag_settle3_cnt", o_cnt, 256);
    applyStimulus(0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
